// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode control-flow blocks:
// instruction target modes, default datapath width and a log2 helper.
package cpu_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [1:0] {
      MODE_NONE = 2'b00,
      MODE_BR   = 2'b01,
      MODE_J    = 2'b10,
      MODE_JR   = 2'b11
   } mode_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/btb_store.sv
// Direct-mapped branch target buffer: one {valid, tag, target} entry per index,
// synchronous write, combinational read that returns pre-write contents.
module btb_store
   import cpu_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_pc,
   input  logic [XLEN-1:0] wr_target,
   input  logic [XLEN-1:0] rd_pc,
   output logic            rd_hit,
   output logic [XLEN-1:0] rd_target
);

   localparam int IDX_W = clog2(DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [TAG_W-1:0] tag_d [DEPTH];
   logic [XLEN-1:0]  tgt_q [DEPTH];
   logic [XLEN-1:0]  tgt_d [DEPTH];
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic             unused_lsbs;

   // Instruction addresses are word aligned, so the two LSBs carry no index/tag information.
   assign unused_lsbs = ^{wr_pc[1:0], rd_pc[1:0]};
   assign wr_idx      = wr_pc[IDX_W+1:2];
   assign rd_idx      = rd_pc[IDX_W+1:2];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      if (wr_en) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = wr_pc[XLEN-1:IDX_W+2];
         tgt_d[wr_idx]   = wr_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
   end

   always_comb begin
      rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc[XLEN-1:IDX_W+2]);
      rd_target = rd_hit ? tgt_q[rd_idx] : '0;
   end

endmodule

// File: rtl/branch_target_unit.sv
// Registered next-PC target stage (branch / jump / jump-register) with stall and
// flush control, redirect generation and a BTB fed by resolved redirects.
module branch_target_unit
   import cpu_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int IMM_W     = 16,
   parameter int JIDX_W    = 26,
   parameter int BTB_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [1:0]        mode,
   input  logic [XLEN-1:0]   pc_plus_4,
   input  logic [IMM_W-1:0]  imm,
   input  logic [JIDX_W-1:0] jidx,
   input  logic [XLEN-1:0]   rs_val,
   input  logic              cond_taken,
   output logic              out_valid,
   output logic              redirect,
   output logic [XLEN-1:0]   target,
   output logic              misalign,
   input  logic [XLEN-1:0]   lk_pc,
   output logic              lk_hit,
   output logic [XLEN-1:0]   lk_target
);

   logic                   valid_q, valid_d;
   mode_e                  mode_q, mode_d;
   logic                   cond_q, cond_d;
   logic [XLEN-1:0]        pc_q, pc_d;
   logic [XLEN-1:0]        target_q, target_d;
   logic signed [XLEN-1:0] imm_sext;
   logic [XLEN-1:0]        calc_target;
   logic                   btb_we;

   always_comb begin
      imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
      case (mode_e'(mode))
         MODE_BR: calc_target = pc_plus_4 + $unsigned(imm_sext <<< 2);
         MODE_J:  calc_target = {pc_plus_4[XLEN-1:JIDX_W+2], jidx, 2'b00};
         MODE_JR: calc_target = rs_val;
         default: calc_target = '0;
      endcase
   end

   // Flush only kills the valid bit; held payload is harmless once invalid.
   always_comb begin
      valid_d  = valid_q;
      mode_d   = mode_q;
      cond_d   = cond_q;
      pc_d     = pc_q;
      target_d = target_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d = in_valid;
         if (in_valid) begin
            mode_d   = mode_e'(mode);
            cond_d   = cond_taken;
            pc_d     = pc_plus_4 - XLEN'(4);
            target_d = calc_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         mode_q   <= MODE_NONE;
         cond_q   <= 1'b0;
         pc_q     <= '0;
         target_q <= '0;
      end else begin
         valid_q  <= valid_d;
         mode_q   <= mode_d;
         cond_q   <= cond_d;
         pc_q     <= pc_d;
         target_q <= target_d;
      end
   end

   assign out_valid = valid_q;
   assign target    = target_q;
   assign misalign  = valid_q && (mode_q == MODE_JR) && (target_q[1:0] != 2'b00);
   assign redirect  = valid_q && !misalign &&
                      ((mode_q == MODE_J) || (mode_q == MODE_JR) || ((mode_q == MODE_BR) && cond_q));

   // A held redirect is recorded exactly once, on the cycle the stage advances.
   assign btb_we = redirect && !stall && !flush && !rst;

   btb_store #(
      .XLEN  (XLEN),
      .DEPTH (BTB_DEPTH)
   ) u_btb (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (btb_we),
      .wr_pc     (pc_q),
      .wr_target (target_q),
      .rd_pc     (lk_pc),
      .rd_hit    (lk_hit),
      .rd_target (lk_target)
   );

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit: directed scenarios plus random traffic,
// checked against an arithmetic reference model of the stage and BTB.
module tb_branch_target_unit;

   logic        clk = 1'b0;
   logic        rst, in_valid, stall, flush, cond_taken;
   logic [1:0]  mode;
   logic [31:0] pc_plus_4, rs_val, lk_pc;
   logic [15:0] imm;
   logic [25:0] jidx;
   logic        out_valid, redirect, misalign, lk_hit;
   logic [31:0] target, lk_target;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        ov, rd, mis, hit;
      logic [31:0] tgt, lkt;
   } exp_t;
   exp_t sbq[$];

   // reference model state
   bit          m_valid;
   int          m_mode;
   bit          m_cond;
   logic [31:0] m_pc4, m_tgt;
   bit          b_valid[8];
   logic [31:0] b_pc[8];
   logic [31:0] b_tgt[8];

   branch_target_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .mode(mode), .pc_plus_4(pc_plus_4), .imm(imm), .jidx(jidx), .rs_val(rs_val),
      .cond_taken(cond_taken), .out_valid(out_valid), .redirect(redirect),
      .target(target), .misalign(misalign), .lk_pc(lk_pc), .lk_hit(lk_hit),
      .lk_target(lk_target)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_target(int md, logic [31:0] p4, logic [15:0] im,
                                               logic [25:0] ji, logic [31:0] rs);
      longint off;
      off = (im >= 16'h8000) ? longint'(im) - 65536 : longint'(im);
      case (md)
         1: return 32'(longint'(p4) + off * 4);
         2: return (p4 & 32'hF000_0000) | (32'(ji) * 4);
         3: return rs;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit m_misalign();
      return m_valid && m_mode == 3 && (m_tgt % 4) != 0;
   endfunction

   function automatic bit m_redirect();
      return m_valid && !m_misalign() && (m_mode == 2 || m_mode == 3 || (m_mode == 1 && m_cond));
   endfunction

   function automatic void model_reset();
      m_valid = 0; m_mode = 0; m_cond = 0; m_pc4 = 0; m_tgt = 0;
      for (int i = 0; i < 8; i++) b_valid[i] = 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the edge, queue what the DUT must show
   // before the next edge, then advance the model across that next edge.
   task automatic step(input logic r, iv, st, fl, input logic [1:0] md, input logic [31:0] p4,
                       input logic [15:0] im, input logic [25:0] ji, input logic [31:0] rs,
                       input logic ct, input logic [31:0] lk);
      exp_t e;
      int   idx;
      @(posedge clk); #1;
      rst = r; in_valid = iv; stall = st; flush = fl; mode = md; pc_plus_4 = p4;
      imm = im; jidx = ji; rs_val = rs; cond_taken = ct; lk_pc = lk;
      idx   = int'((lk >> 2) % 8);
      e.ov  = m_valid;
      e.rd  = m_redirect();
      e.mis = m_misalign();
      e.tgt = m_tgt;
      e.hit = b_valid[idx] && ((b_pc[idx] >> 5) == (lk >> 5));
      e.lkt = e.hit ? b_tgt[idx] : 32'h0;
      sbq.push_back(e);
      if (r) begin
         model_reset();
      end else begin
         if (!fl && !st && m_redirect()) begin
            idx = int'(((m_pc4 - 4) >> 2) % 8);
            b_valid[idx] = 1; b_pc[idx] = m_pc4 - 4; b_tgt[idx] = m_tgt;
         end
         if (fl) m_valid = 0;
         else if (!st) begin
            m_valid = iv;
            if (iv) begin
               m_mode = int'(md); m_cond = ct; m_pc4 = p4;
               m_tgt  = ref_target(int'(md), p4, im, ji, rs);
            end
         end
      end
   endtask

   task automatic op(input logic [1:0] md, input logic [31:0] p4, input logic [15:0] im,
                     input logic [25:0] ji, input logic [31:0] rs, input logic ct, input logic [31:0] lk);
      step(0, 1, 0, 0, md, p4, im, ji, rs, ct, lk);
   endtask

   task automatic idle(input logic [31:0] lk);
      step(0, 0, 0, 0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0, 0, lk);
   endtask

   // monitor: pops one expectation per cycle, mid-cycle
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("out_valid", 32'(out_valid), 32'(e.ov));
         chk("redirect",  32'(redirect),  32'(e.rd));
         chk("misalign",  32'(misalign),  32'(e.mis));
         chk("target",    target,         e.tgt);
         chk("lk_hit",    32'(lk_hit),    32'(e.hit));
         chk("lk_target", lk_target,      e.lkt);
      end
   end

   initial begin
      logic [31:0] p4, lk;
      logic [1:0]  md;
      rst = 1; in_valid = 0; stall = 0; flush = 0; mode = 0; pc_plus_4 = 0;
      imm = 0; jidx = 0; rs_val = 0; cond_taken = 0; lk_pc = 0;
      model_reset();
      step(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0040000C);

      // branch backwards, taken then not taken
      op(2'd1, 32'h0040_0010, 16'hFFFE, 0, 0, 1, 32'h0);
      op(2'd1, 32'h0040_0010, 16'hFFFE, 0, 0, 0, 32'h0);
      @(negedge clk);
      chk("dir_br_target", target, 32'h0040_0008);
      chk("dir_br_redirect", 32'(redirect), 32'd1);
      idle(32'h0040_000C);
      @(negedge clk);
      chk("dir_nt_redirect", 32'(redirect), 32'd0);
      chk("dir_nt_target", target, 32'h0040_0008);
      chk("dir_btb_hit", 32'(lk_hit), 32'd1);
      chk("dir_btb_target", lk_target, 32'h0040_0008);
      idle(32'h0040_100C);
      @(negedge clk);
      chk("dir_btb_tagmiss", 32'(lk_hit), 32'd0);

      // jump, wrapping branch, jr aligned and misaligned
      op(2'd2, 32'h1000_0004, 0, 26'h0000100, 0, 0, 32'h0);
      op(2'd1, 32'hFFFF_FFF0, 16'h0010, 0, 0, 1, 32'h0);
      @(negedge clk);
      chk("dir_j_target", target, 32'h1000_0400);
      op(2'd3, 32'h0040_0200, 0, 0, 32'h0040_0020, 0, 32'h0);
      @(negedge clk);
      chk("dir_wrap_target", target, 32'h0000_0030);
      op(2'd3, 32'h0040_0100, 0, 0, 32'h0040_0022, 0, 32'h0);
      @(negedge clk);
      chk("dir_jr_redirect", 32'(redirect), 32'd1);
      idle(32'h0);
      @(negedge clk);
      chk("dir_jr_misalign", 32'(misalign), 32'd1);
      chk("dir_jr_mis_redirect", 32'(redirect), 32'd0);
      idle(32'h0040_00FC);
      @(negedge clk);
      chk("dir_mis_no_write", 32'(lk_hit), 32'd0);

      // stall holds a jump for three cycles, then flush under stall
      op(2'd2, 32'h2000_0000, 0, 26'h3, 0, 0, 32'h1FFF_FFFC);
      for (int i = 0; i < 3; i++)
         step(0, 1, 1, 0, 2'd1, 32'h0, 16'h7, 0, 0, 1, 32'h1FFF_FFFC);
      idle(32'h1FFF_FFFC);
      idle(32'h1FFF_FFFC);
      op(2'd2, 32'h3000_0040, 0, 26'h55, 0, 0, 32'h0);
      step(0, 1, 1, 1, 2'd3, 32'h0, 0, 0, 32'h4, 0, 32'h3000_003C);
      idle(32'h3000_003C);
      idle(32'h3000_003C);

      // reset mid-operation with a populated BTB
      op(2'd2, 32'h4000_0008, 0, 26'h9, 0, 0, 32'h0040_000C);
      step(1, 1, 0, 0, 2'd2, 32'h4000_0010, 0, 26'h9, 0, 0, 32'h0040_000C);
      idle(32'h0040_000C);
      idle(32'h0040_0004);

      // random traffic over a small PC pool so the BTB sees hits and overwrites
      for (int n = 0; n < 600; n++) begin
         p4 = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                           : 32'h0040_0000 + 32'($urandom_range(1, 64) * 4);
         case ($urandom_range(0, 3))
            0: lk = b_pc[$urandom_range(0, 7)];
            1: lk = m_pc4 - 4;
            2: lk = (m_pc4 - 4) ^ 32'h0000_1000;
            default: lk = $urandom;
         endcase
         md = 2'($urandom_range(0, 3));
         step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
              $urandom_range(0, 9) < 1, md, p4, 16'($urandom), 26'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
              1'($urandom), lk);
      end

      @(negedge clk); #1;
      vectors++;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
